// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and instruction/data memory.
// Signal direction suffixes are relative to the controller.
interface multicycle_ctrl_if;
  logic imem_req_o;
  logic imem_ack_i;
  logic dmem_req_o;
  logic dmem_we_o;
  logic dmem_ack_i;

  modport master (
    output imem_req_o,
    output dmem_req_o,
    output dmem_we_o,
    input  imem_ack_i,
    input  dmem_ack_i
  );

  modport slave (
    input  imem_req_o,
    input  dmem_req_o,
    input  dmem_we_o,
    output imem_ack_i,
    output dmem_ack_i
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset (R-type, addi, lw, sw, beq).
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [31:0]              instr_i,
  input  logic                     zero_i,
  multicycle_ctrl_if.master        mem_if,
  output logic                     ir_we_o,
  output logic                     pc_we_o,
  output logic                     pc_src_o,
  output logic                     reg_we_o,
  output logic                     alu_src_o,
  output logic [1:0]               alu_op_o,
  output logic [1:0]               imm_sel_o,
  output logic                     mem_to_reg_o,
  output logic [2:0]               state_o,
  output logic                     err_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]              retired_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [6:0] opcode_r;
  logic       retire_s;
  logic       timeout_s;
  logic       imem_req_s;
  logic       dmem_req_s;
  logic       dmem_we_s;
  logic       unused_instr_s;

  assign unused_instr_s = ^instr_i[31:7];

  function automatic logic [1:0] imm_sel_f(input logic [6:0] opcode);
    logic [1:0] sel;
    case (opcode)
      OP_SW:   sel = 2'b01;
      OP_BEQ:  sel = 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  // Next-state and output decode from current state and latched opcode
  always_comb begin
    state_nxt_s  = state_r;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 1'b0;
    reg_we_o     = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 2'b00;
    imm_sel_o    = 2'b00;
    mem_to_reg_o = 1'b0;
    err_o        = 1'b0;
    retire_s     = 1'b0;
    timeout_s    = (cnt_r == TIMEOUT_LAST);
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (mem_if.imem_ack_i) begin
          ir_we_o     = 1'b1;
          pc_we_o     = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (timeout_s) begin
          state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        imm_sel_o = imm_sel_f(opcode_r);
        case (instr_i[6:0])
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_nxt_s = ST_EXEC;
          default:                             state_nxt_s = ST_ERROR;
        endcase
      end
      ST_EXEC: begin
        imm_sel_o = imm_sel_f(opcode_r);
        case (opcode_r)
          OP_R: begin
            alu_op_o    = 2'b10;
            state_nxt_s = ST_WB;
          end
          OP_ADDI: begin
            alu_src_o   = 1'b1;
            state_nxt_s = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_o   = 1'b1;
            state_nxt_s = ST_MEM;
          end
          OP_BEQ: begin
            alu_op_o    = 2'b01;
            pc_src_o    = 1'b1;
            pc_we_o     = zero_i;
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end
          default: state_nxt_s = ST_ERROR;
        endcase
      end
      ST_MEM: begin
        imm_sel_o  = imm_sel_f(opcode_r);
        dmem_req_s = 1'b1;
        dmem_we_s  = (opcode_r == OP_SW);
        if (mem_if.dmem_ack_i) begin
          if (opcode_r == OP_SW) begin
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WB;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        imm_sel_o    = imm_sel_f(opcode_r);
        reg_we_o     = 1'b1;
        mem_to_reg_o = (opcode_r == OP_LW);
        retire_s     = 1'b1;
        state_nxt_s  = ST_FETCH;
      end
      ST_ERROR: begin
        err_o       = 1'b1;
        state_nxt_s = ST_ERROR;
      end
      default: state_nxt_s = ST_ERROR;
    endcase
    // Counter restarts on every state change so each request gets a fresh budget
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = 8'd0;
    end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = 8'd0;
    end
  end

  assign mem_if.imem_req_o = imem_req_s;
  assign mem_if.dmem_req_o = dmem_req_s;
  assign mem_if.dmem_we_o  = dmem_we_s;
  assign state_o           = state_r;

  // State, timeout counter and opcode latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 8'd0;
      opcode_r <= 7'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (state_r == ST_DECODE) begin
        opcode_r <= instr_i[6:0];
      end
    end
  end

`ifdef PERF_CNT_EN
  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_o <= 32'd0;
    end else if (retire_s) begin
      retired_o <= retired_o + 32'd1;
    end
  end
`endif

endmodule
